// File: rtl/bf16_pkg.sv
// ============================================================================
// Module      : bf16_pkg
// Description : Shared bfloat16 field widths, value classes and packed layout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bf16_pkg;

    localparam int BF16_EXP_W = 8;
    localparam int BF16_MAN_W = 7;
    localparam int BF16_BIAS  = 127;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } bf16_class_t;

    typedef struct packed {
        logic                  sign;
        logic [BF16_EXP_W-1:0] exp;
        logic [BF16_MAN_W-1:0] man;
    } bf16_t;

endpackage

`default_nettype wire

// File: rtl/bf16_int_shift.sv
// ============================================================================
// Module      : bf16_int_shift
// Description : Combinational shift, optional round, negate and saturate of a
//               decoded bf16 value. BF16_TO_SINT_RNE_EN selects round-to-
//               nearest-even; otherwise the magnitude truncates toward zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bf16_int_shift
    import bf16_pkg::*;
#(
    parameter int OUT_W = 24
) (
    input  logic              sign_i,
    input  bf16_class_t       cls_i,
    input  logic signed [8:0] k_i,
    input  logic [7:0]        sig_i,
    output logic [OUT_W-1:0]  sint_o,
    output logic              ovf_o,
    output logic              nan_o
);

    localparam logic signed [8:0] c_K_SAT   = 9'(OUT_W - 1);
    localparam logic [OUT_W-1:0]  c_POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]  c_NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [3:0]       w_rsh;
    logic [4:0]       w_lsh;
    logic [7:0]       w_small;
    logic [OUT_W-1:0] w_mag;
    logic             w_sat;

    // Only meaningful inside their respective k ranges (-1..6 and 7..OUT_W-2).
    assign w_rsh = 4'(9'sd7 - k_i);
    assign w_lsh = 5'(k_i - 9'sd7);

`ifdef BF16_TO_SINT_RNE_EN
    logic [15:0] w_wide;
    logic        w_rnd_up;

    assign w_wide   = {sig_i, 8'h00} >> w_rsh;
    assign w_rnd_up = w_wide[7] & ((|w_wide[6:0]) | w_wide[8]);
    assign w_small  = w_wide[15:8] + {7'd0, w_rnd_up};
`else
    assign w_small  = sig_i >> w_rsh;
`endif

    always_comb begin
        w_mag = '0;
        w_sat = 1'b0;
        ovf_o = 1'b0;
        nan_o = 1'b0;
        unique case (cls_i)
            CLS_NAN: nan_o = 1'b1;
            CLS_INF: begin
                w_sat = 1'b1;
                ovf_o = 1'b1;
            end
            CLS_NORM: begin
                if (k_i >= c_K_SAT) begin
                    w_sat = 1'b1;
                    // -2^(OUT_W-1) itself is representable, so no overflow there.
                    ovf_o = !(sign_i && (k_i == c_K_SAT) && (sig_i[6:0] == 7'd0));
                end else if (k_i >= 9'sd7) begin
                    w_mag = OUT_W'(sig_i) << w_lsh;
                end else if (k_i >= -9'sd1) begin
                    w_mag = OUT_W'(w_small);
                end
            end
            default: ;
        endcase

        if (w_sat) begin
            sint_o = sign_i ? c_NEG_MIN : c_POS_MAX;
        end else begin
            sint_o = sign_i ? (-w_mag) : w_mag;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bf16_to_sint24.sv
// ============================================================================
// Module      : bf16_to_sint24
// Description : Two-stage valid/ready bfloat16 to signed integer converter
//               with saturation and NaN flag. Define BF16_TO_SINT_RNE_EN for
//               round-to-nearest-even instead of truncation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bf16_to_sint24
    import bf16_pkg::*;
#(
    parameter int OUT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      bf16_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] sint_out,
    output logic             ovf,
    output logic             nan
);

    bf16_t             w_in;
    logic              w_s1_en;
    logic              w_s2_en;

    bf16_class_t       cls_d;
    logic signed [8:0] k_d;
    logic [7:0]        sig_d;

    logic              s1_valid_q;
    logic              s1_sign_q;
    bf16_class_t       s1_cls_q;
    logic signed [8:0] s1_k_q;
    logic [7:0]        s1_sig_q;

    logic [OUT_W-1:0]  sint_d;
    logic              ovf_d;
    logic              nan_d;

    logic              s2_valid_q;
    logic [OUT_W-1:0]  sint_q;
    logic              ovf_q;
    logic              nan_q;

    assign w_in     = bf16_in;
    assign w_s2_en  = !s2_valid_q || out_ready;
    assign w_s1_en  = !s1_valid_q || w_s2_en;
    assign in_ready = w_s1_en;

    // Denormals flush to zero.
    always_comb begin
        cls_d = CLS_NORM;
        if (w_in.exp == '0) begin
            cls_d = CLS_ZERO;
        end else if (w_in.exp == '1) begin
            cls_d = (w_in.man == '0) ? CLS_INF : CLS_NAN;
        end
    end

    assign k_d   = $signed({1'b0, w_in.exp}) - $signed(9'(BF16_BIAS));
    assign sig_d = {1'b1, w_in.man};

    bf16_int_shift #(
        .OUT_W (OUT_W)
    ) u_shift (
        .sign_i (s1_sign_q),
        .cls_i  (s1_cls_q),
        .k_i    (s1_k_q),
        .sig_i  (s1_sig_q),
        .sint_o (sint_d),
        .ovf_o  (ovf_d),
        .nan_o  (nan_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_cls_q   <= CLS_ZERO;
            s1_k_q     <= '0;
            s1_sig_q   <= '0;
            s2_valid_q <= 1'b0;
            sint_q     <= '0;
            ovf_q      <= 1'b0;
            nan_q      <= 1'b0;
        end else begin
            if (w_s1_en) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_sign_q <= w_in.sign;
                    s1_cls_q  <= cls_d;
                    s1_k_q    <= k_d;
                    s1_sig_q  <= sig_d;
                end
            end
            if (w_s2_en) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    sint_q <= sint_d;
                    ovf_q  <= ovf_d;
                    nan_q  <= nan_d;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign sint_out  = sint_q;
    assign ovf       = ovf_q;
    assign nan       = nan_q;

endmodule

`default_nettype wire

// File: tb/tb_bf16_to_sint24.sv
// ============================================================================
// Module      : tb_bf16_to_sint24
// Description : Self-checking bench for bf16_to_sint24 (value-level model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bf16_to_sint24;

    localparam int OUT_W = 24;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [15:0]      bf16_in   = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] sint_out;
    logic             ovf;
    logic             nan;

    int               checks = 0;
    int               errors = 0;
    logic [OUT_W+1:0] exp_q[$];
    bit               rand_busy;

    bf16_to_sint24 #(.OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bf16_in   (bf16_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sint_out  (sint_out),
        .ovf       (ovf),
        .nan       (nan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Reference: exact real value of the bf16, rounded, then clamped to range.
    function automatic logic [OUT_W+1:0] model(input logic [15:0] x);
        int     ex, mn;
        real    v, sc;
        longint m, sv, hi, lo;
        logic   o, n;
`ifdef BF16_TO_SINT_RNE_EN
        real    fr;
`endif
        hi = (longint'(1) <<< (OUT_W-1)) - 1;
        lo = -(longint'(1) <<< (OUT_W-1));
        ex = int'(x[14:7]);
        mn = int'(x[6:0]);
        o  = 1'b0;
        n  = 1'b0;
        sv = 0;
        if (ex == 255) begin
            if (mn != 0) n = 1'b1;
            else begin
                sv = x[15] ? lo : hi;
                o  = 1'b1;
            end
        end else if (ex != 0) begin
            sc = 1.0;
            for (int i = 0; i < ex - 134; i++) sc = sc * 2.0;
            for (int i = 0; i < 134 - ex; i++) sc = sc / 2.0;
            v = real'(128 + mn) * sc;
            if (v > 1.0e9) v = 1.0e9;
            m = longint'($rtoi(v));
`ifdef BF16_TO_SINT_RNE_EN
            fr = v - real'(m);
            if (fr > 0.5 || (fr == 0.5 && m[0])) m = m + 1;
`endif
            sv = x[15] ? -m : m;
            if (sv > hi) begin
                sv = hi;
                o  = 1'b1;
            end else if (sv < lo) begin
                sv = lo;
                o  = 1'b1;
            end
        end
        return {sv[OUT_W-1:0], o, n};
    endfunction

    // Scoreboard: push on accepted input, compare head on every valid output.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sb_spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("sb_result", 32'({sint_out, ovf, nan}), 32'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(bf16_in));
        end
    end

    task automatic send(input logic [15:0] x);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        bf16_in  = x;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [15:0] x,
                            input logic [23:0] s, input logic o, input logic n);
        bit seen;
        seen = 1'b0;
        send(x);
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sint"},  32'(sint_out),  32'(s));
        chk({tag, "_ovf"},   32'(ovf),       32'(o));
        chk({tag, "_nan"},   32'(nan),       32'(n));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] bp[4];
        int          idx;
        bit          acc;
        logic [15:0] x;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sint",      32'(sint_out),  32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        chk("rst_nan",       32'(nan),       32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Two-cycle latency on 1.0
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(16'h3F80);
        @(negedge clk);
        chk("lat_c1_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_c2_out_valid", 32'(out_valid), 32'd1);
        chk("lat_sint", 32'(sint_out), 32'h000001);
        chk("lat_ovf",  32'(ovf), 32'd0);
        chk("lat_nan",  32'(nan), 32'd0);
        @(posedge clk);
        #1;

        // Directed values and boundaries
`ifdef BF16_TO_SINT_RNE_EN
        directed("m123p5",  16'hC2F7, 24'hFFFF84, 1'b0, 1'b0);
        directed("p1p5",    16'h3FC0, 24'h000002, 1'b0, 1'b0);
        directed("p0p75",   16'h3F40, 24'h000001, 1'b0, 1'b0);
`else
        directed("m123p5",  16'hC2F7, 24'hFFFF85, 1'b0, 1'b0);
        directed("p1p5",    16'h3FC0, 24'h000001, 1'b0, 1'b0);
        directed("p0p75",   16'h3F40, 24'h000000, 1'b0, 1'b0);
`endif
        directed("p2e23",   16'h4B00, 24'h7FFFFF, 1'b1, 1'b0);
        directed("m2e23",   16'hCB00, 24'h800000, 1'b0, 1'b0);
        directed("m2e23b",  16'hCB01, 24'h800000, 1'b1, 1'b0);
        directed("minf",    16'hFF80, 24'h800000, 1'b1, 1'b0);
        directed("pinf",    16'h7F80, 24'h7FFFFF, 1'b1, 1'b0);
        directed("nan",     16'h7FC0, 24'h000000, 1'b0, 1'b1);
        directed("mzero",   16'h8000, 24'h000000, 1'b0, 1'b0);
        directed("p0p5",    16'h3F00, 24'h000000, 1'b0, 1'b0);
        directed("m0p5",    16'hBF00, 24'h000000, 1'b0, 1'b0);
        directed("denorm",  16'h0001, 24'h000000, 1'b0, 1'b0);
        directed("k22max",  16'h4AFF, 24'h7F8000, 1'b0, 1'b0);
        directed("m1",      16'hBF80, 24'hFFFFFF, 1'b0, 1'b0);

        // Backpressure: four offered, two accepted while output is stalled
        bp[0] = 16'h3F80; bp[1] = 16'h4000; bp[2] = 16'h4040; bp[3] = 16'h4080;
        out_ready = 1'b0;
        idx       = 0;
        in_valid  = 1'b1;
        bf16_in   = bp[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                bf16_in = bp[idx];
            end
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        @(negedge clk);
        chk("bp_in_ready",  32'(in_ready),  32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_sint", 32'(sint_out),  32'h000001);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_tput_out_valid", 32'(out_valid), 32'd1);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 4) bf16_in = bp[idx];
                else in_valid = 1'b0;
            end
        end
        chk("bp_all_sent", 32'(idx), 32'd4);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        send(16'h4100);
        send(16'h4110);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_sint",      32'(sint_out),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("arst_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(16'h4120);
        @(negedge clk);
        chk("arst_lat_c1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("arst_lat_c2",   32'(out_valid), 32'd1);
        chk("arst_lat_sint", 32'(sint_out),  32'd10);
        @(posedge clk);
        #1;

        // Randomized traffic with random output stalls
        rand_busy = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) x = 16'($urandom);
                    else x = {1'($urandom), 8'($urandom_range(110, 155)), 7'($urandom)};
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(x);
                end
                rand_busy = 1'b0;
            end
            begin
                while (rand_busy) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bf16_to_sint24.md
Name: bf16_to_sint24

Overview:
Streaming converter from bfloat16 to signed 24-bit two's-complement integer. It is the inverse of the datapath's integer-to-bf16 path and sits on the result side of the matrix multiplier, where bf16 accumulator outputs go back into the integer domain. It is a 2-stage valid/ready pipeline with full backpressure and one result per cycle. Default rounding truncates toward zero. Out-of-range inputs saturate, and NaN inputs are flagged.

Parameters:
OUT_W, 24, output integer width; legal range 9..32; all saturation thresholds derive from it.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  bf16_in is valid
in_ready  out  1  block accepts bf16_in this cycle
bf16_in  in  16  {sign, exp[7:0], man[6:0]}
out_valid  out  1  result fields are valid
out_ready  in  1  downstream accepts the result
sint_out  out  OUT_W  converted integer, two's complement
ovf  out  1  result was saturated (includes +/-inf)
nan  out  1  input was NaN; sint_out is 0

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, sint_out=0, ovf=0, nan=0.
  - Internal stage valids are cleared.
  - in_ready=1 once rst_n is high.
  - Reset mid-operation discards all in-flight data; no partial results appear.
- Handshake:
  - A transfer occurs on a cycle where valid and ready are both 1.
  - s2_en = !s2_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
  - in_ready = s1_en (combinational; no path from in_valid to in_ready).
  - Outputs hold stable while out_valid=1 and out_ready=0.
- Latency: 2 cycles from input acceptance to out_valid with no stall. Throughput 1/cycle. Order is preserved.
- Stage 1 (decode):
  - Registers sign, class and k = exp-127 (signed 9-bit), plus sig = {1, man} (8 bits).
  - Class: ZERO if exp==0 (denormals flush to zero); INF if exp==255 and man==0; NAN if exp==255 and man!=0; otherwise NORM.
- Stage 2 (shift, negate, saturate), registered into the outputs:
  - ZERO, or NORM with k<0: magnitude 0, so sint_out=0.
  - NORM, 0<=k<=6: mag = sig >> (7-k), fractional bits dropped.
  - NORM, 7<=k<=OUT_W-2: mag = sig << (k-7).
  - NORM, k>=OUT_W-1: saturate:
    - positive gives 2^(OUT_W-1)-1 with ovf=1;
    - negative gives -2^(OUT_W-1);
    - ovf=0 only when k==OUT_W-1 and man==0 (exactly representable), otherwise ovf=1.
  - INF: saturate by sign, ovf=1.
  - NAN: sint_out=0, nan=1, ovf=0.
  - Sign applied as -mag. A zero magnitude with sign=1 yields 0, never a negative zero pattern.
- ovf and nan are per-result flags, not sticky. They are valid with out_valid.

Optional Feature:
Macro BF16_TO_SINT_RNE_EN.
- Defined: round to nearest, ties to even, applied to magnitude before negation.
  - Uses guard bit plus sticky bit of the bits shifted out for 0<=k<=6.
  - k==-1: value >0.5 gives 1; exactly 0.5 gives 0.
  - k<=-2: gives 0.
  - Rounding can never cause overflow, because fractional bits exist only for k<=6.
- Undefined: truncation toward zero. No added logic, latency unchanged.

Decomposition:
- Package bf16_pkg:
  - BF16_EXP_W=8, BF16_MAN_W=7, BF16_BIAS=127;
  - typedef enum bf16_class_t {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN};
  - packed struct bf16_t {sign, exp, man}.
- One sub-module, bf16_int_shift: combinational stage-2 shift, round, negate and saturate. It is parameterised by OUT_W and instantiated between the stage registers.

Test Plan:
- 1.0: 0x3F80 accepted, out_ready=1 -> exactly 2 cycles later sint_out=0x000001, ovf=0, nan=0.
- -123.5: 0xC2F7 -> 0xFFFF85 (-123) by default; 0xFFFF84 (-124, tie to even) with BF16_TO_SINT_RNE_EN.
- Saturation edges:
  - 0x4B00 (+2^23) -> 0x7FFFFF, ovf=1;
  - 0xCB00 -> 0x800000, ovf=0;
  - 0xCB01 -> 0x800000, ovf=1;
  - 0xFF80 (-inf) -> 0x800000, ovf=1.
- Specials: 0x7FC0 (NaN) -> 0x000000, nan=1. 0x8000 (-0) -> 0x000000. 0x3F00 (0.5) -> 0 in both modes. 0x0001 (denormal) -> 0.
- Backpressure: out_ready=0 for 5 cycles while 4 back-to-back inputs are offered:
  - only 2 are accepted, then in_ready=0;
  - outputs stay stable;
  - after release, all 4 results emerge in order, 1/cycle.
- Reset mid-stream: assert rst_n=0 with both stages full -> out_valid=0 immediately (asynchronous). After release, no stale result appears; the next input has a 2-cycle latency.
